// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and deferred-write record for the writeback port arbiter
package wb_pkg;

  // Register that receives multdiv exception codes, and the codes themselves
  localparam int EXC_REG = 30;
  localparam int EXC_MUL = 4;
  localparam int EXC_DIV = 5;

  // Default number of deferred multdiv result slots
  localparam int DEFAULT_DEPTH = 2;

  // One deferred register write; live drops when a newer write to the same
  // register makes this one obsolete
  typedef struct packed {
    logic        live;
    logic [4:0]  regno;
    logic [31:0] data;
  } wb_entry_t;

  // One-hot register bit, used to build the pending-write mask
  function automatic logic [31:0] reg_bit(input logic [4:0] r);
    return 32'h1 << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - deferred multdiv write queue with per-register kill and live mask
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [4:0]                 push_reg,
  input  logic [31:0]                push_data,
  input  logic                       pop,
  input  logic                       kill_a,
  input  logic [4:0]                 kill_a_reg,
  input  logic                       kill_b,
  input  logic [4:0]                 kill_b_reg,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                live_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     slots [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          do_pop;
  logic          do_push;

  // Circular pointer advance that also works for non-power-of-two depths
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Popping an empty queue or pushing a full one without a pop is ignored
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  assign head = slots[head_ptr];

  // Queue state: kills hit existing entries first, then pop retires the head,
  // then push fills the tail (which may be the slot just freed when full)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((kill_a && (slots[i].regno == kill_a_reg)) ||
            (kill_b && (slots[i].regno == kill_b_reg))) begin
          slots[i].live <= 1'b0;
        end
      end
      if (do_pop) begin
        slots[head_ptr].live <= 1'b0;
        head_ptr             <= bump(head_ptr);
      end
      if (do_push) begin
        slots[tail_ptr].live  <= 1'b1;
        slots[tail_ptr].regno <= push_reg;
        slots[tail_ptr].data  <= push_data;
        tail_ptr              <= bump(tail_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Pending-write mask from live entries; register 0 is never pending
  always_comb begin
    live_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots[i].live) begin
        live_mask = live_mask | reg_bit(slots[i].regno);
      end
    end
    live_mask[0] = 1'b0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register file write port shared by the pipeline and the multdiv unit
module wb_port_arbiter
  import wb_pkg::wb_entry_t;
  import wb_pkg::DEFAULT_DEPTH;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int EXC_REG = wb_pkg::EXC_REG,
  parameter int EXC_MUL = wb_pkg::EXC_MUL,
  parameter int EXC_DIV = wb_pkg::EXC_DIV
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic        md_op,
  input  logic        md_exc,
  output logic        rf_we,
  output logic [4:0]  rf_reg,
  output logic [31:0] rf_data,
  output logic        md_stall,
  output logic [31:0] pend_mask,
  output logic        overflow
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);

  logic          wb_sel;
  logic [4:0]    md_reg_eff;
  logic [31:0]   md_data_eff;
  logic          md_ok;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          md_enq;
  logic          push;
  logic          ovf_set;
  wb_entry_t     head;
  logic [CW-1:0] count;
  logic [31:0]   live_mask;
  logic          sel_we;
  logic [4:0]    sel_reg;
  logic [31:0]   sel_data;

  // Exceptions redirect the result to the exception register with a fixed code
  always_comb begin
    md_reg_eff  = md_exc ? 5'(EXC_REG) : md_reg;
    md_data_eff = md_exc ? (md_op ? 32'(EXC_DIV) : 32'(EXC_MUL)) : md_data;
  end

  // A pipeline write to r0 is no write at all, so it leaves the port idle
  assign wb_sel     = wb_valid && (wb_reg != 5'd0);
  assign md_ok      = md_valid && (md_reg_eff != 5'd0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL);

  // The head drains only when the pipeline leaves the port free
  assign pop     = !wb_sel && !fifo_empty;
  // A result bypasses the queue only if nothing older could be overtaken
  assign md_enq  = md_ok && (wb_sel || !fifo_empty);
  assign push    = md_enq && (!fifo_full || pop);
  assign ovf_set = md_enq && fifo_full && !pop;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_reg   (md_reg_eff),
    .push_data  (md_data_eff),
    .pop        (pop),
    .kill_a     (wb_sel),
    .kill_a_reg (wb_reg),
    .kill_b     (push),
    .kill_b_reg (md_reg_eff),
    .head       (head),
    .count      (count),
    .live_mask  (live_mask)
  );

  // Write source priority: pipeline, then direct multdiv, then live queue head
  always_comb begin
    sel_we   = 1'b0;
    sel_reg  = 5'd0;
    sel_data = 32'd0;
    if (wb_sel) begin
      sel_we   = 1'b1;
      sel_reg  = wb_reg;
      sel_data = wb_data;
    end else if (md_ok && fifo_empty) begin
      sel_we   = 1'b1;
      sel_reg  = md_reg_eff;
      sel_data = md_data_eff;
    end else if (!fifo_empty && head.live && (head.regno != 5'd0)) begin
      sel_we   = 1'b1;
      sel_reg  = head.regno;
      sel_data = head.data;
    end
  end

  // Registered register-file write port and sticky lost-result flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_reg   <= 5'd0;
      rf_data  <= 32'd0;
      overflow <= 1'b0;
    end else begin
      rf_we   <= sel_we;
      rf_reg  <= sel_reg;
      rf_data <= sel_data;
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  // Stall one slot early so an issued op always finds room; held low in reset
  assign md_stall  = reset && (count >= STALL_AT);
  assign pend_mask = live_mask;

endmodule
